sensor_serializer_mc: RTL and testbench

Multi-channel successor to the single-bank sensor serializer. It has an AXI4-Lite slave register file holding N_CHANNELS sensor values. A scan engine walks the enabled channels and shifts each one out as a framed serial word: channel ID, value MSB-first, even parity. Bit rate is programmable. The block sits between the IPMC processor AXI interconnect and the off-board sensor link.

---
 rtl/sensor_serializer_mc_pkg.sv | 27 ++
 rtl/sensor_serializer_mc_shifter.sv | 81 ++++++++
 rtl/sensor_serializer_mc.sv | 232 +++++++++++++++++++++++
 tb/tb_sensor_serializer_mc.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_serializer_mc_pkg.sv
// Shared constants, FSM state type and byte-strobe merge helper for the
// multi-channel sensor serializer.
package sensor_serializer_mc_pkg;

  localparam int REG_CTRL    = 'h00;
  localparam int REG_STATUS  = 'h04;
  localparam int REG_CLKDIV  = 'h08;
  localparam int REG_CHEN    = 'h0C;
  localparam int REG_CH_BASE = 'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, SEEK, LOAD, SHIFT, GAP, DONE} state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sensor_serializer_mc_shifter.sv
// Bit-period divider and shift register. A start with frame_i=1 sends a data
// frame; frame_i=0 runs two silent bit periods (inter-frame gap).
module sensor_serializer_mc_shifter #(
  parameter int FRAME_LEN = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 frame_i,
  input  logic [FRAME_LEN-1:0] data_i,
  input  logic [15:0]          clkdiv_i,
  output logic                 ser_clk_o,
  output logic                 ser_data_o,
  output logic                 ser_frame_o,
  output logic                 done_o
);

  logic                 run_q, run_d;
  logic                 frame_q, frame_d;
  logic [FRAME_LEN-1:0] sh_q, sh_d;
  logic [15:0]          div_q, div_d;
  logic [16:0]          cnt_q, cnt_d;
  logic [7:0]           bits_q, bits_d;
  logic                 period_end;

  // A period is 2*(div+1) cycles, so its last count is 2*div+1.
  assign period_end  = (cnt_q == {div_q, 1'b1});
  assign done_o      = run_q && period_end && (bits_q == 8'd1);
  assign ser_frame_o = run_q && frame_q;
  assign ser_clk_o   = ser_frame_o && (cnt_q > {1'b0, div_q});
  assign ser_data_o  = ser_frame_o && sh_q[FRAME_LEN-1];

  always_comb begin
    run_d   = run_q;
    frame_d = frame_q;
    sh_d    = sh_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    if (start_i) begin
      run_d   = 1'b1;
      frame_d = frame_i;
      cnt_d   = '0;
      sh_d    = frame_i ? data_i : '0;
      // The gap keeps the divider latched for the frame it follows.
      div_d   = frame_i ? clkdiv_i : div_q;
      bits_d  = frame_i ? 8'(FRAME_LEN) : 8'd2;
    end else if (run_q) begin
      if (period_end) begin
        cnt_d = '0;
        if (bits_q == 8'd1) begin
          run_d = 1'b0;
        end else begin
          bits_d = bits_q - 8'd1;
          sh_d   = sh_q << 1;
        end
      end else begin
        cnt_d = cnt_q + 17'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q   <= 1'b0;
      frame_q <= 1'b0;
      sh_q    <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      bits_q  <= '0;
    end else begin
      run_q   <= run_d;
      frame_q <= frame_d;
      sh_q    <= sh_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
    end
  end

endmodule

// File: rtl/sensor_serializer_mc.sv
// AXI4-Lite register file and channel scan engine; frames are shifted out by
// sensor_serializer_mc_shifter.
module sensor_serializer_mc #(
  parameter int N_CHANNELS         = 8,
  parameter int DATA_WIDTH         = 16,
  parameter int CH_BITS            = 5,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int DIV_RESET          = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic                          SER_CLK,
  output logic                          SER_DATA,
  output logic                          SER_FRAME,
  output logic                          SCAN_DONE
);
  import sensor_serializer_mc_pkg::*;

  localparam int FRAME_LEN = CH_BITS + DATA_WIDTH + 1;
  localparam int IDX_W     = CH_BITS + 1;

  logic                  cont_q, cont_d, go_q, go_d;
  logic [15:0]           clkdiv_q, clkdiv_d, framecnt_q, framecnt_d;
  logic [N_CHANNELS-1:0] chen_q, chen_d;
  logic [DATA_WIDTH-1:0] ch_q [N_CHANNELS];
  logic [DATA_WIDTH-1:0] ch_d [N_CHANNELS];
  logic                  accept_q, accept_d, bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d, wr_val;
  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [2**IDX_W-1:0]   chen_ext;
  logic [DATA_WIDTH-1:0] ch_sel;
  logic [FRAME_LEN-1:0]  frame_word;
  logic                  busy, sh_start, sh_frame, sh_done;
  logic [32:0]           wr_info, rd_info;
  int                    wr_word, rd_word;

  assign busy = (state_q != IDLE);

  // Returns {mapped, readback value} for a word address.
  function automatic logic [32:0] reg_read(input int word);
    logic [32:0] r;
    r = '0;
    if (word == REG_CTRL / 4)        r = {1'b1, 31'b0, cont_q};
    else if (word == REG_STATUS / 4) r = {1'b1, 8'b0, framecnt_q, 7'b0, busy};
    else if (word == REG_CLKDIV / 4) r = {1'b1, 16'b0, clkdiv_q};
    else if (word == REG_CHEN / 4)   r = {1'b1, 32'(chen_q)};
    else begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        if (word == REG_CH_BASE / 4 + i) r = {1'b1, 32'(ch_q[i])};
      end
    end
    return r;
  endfunction

  always_comb begin
    wr_word = int'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
    rd_word = int'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
    wr_info = reg_read(wr_word);
    rd_info = reg_read(rd_word);
    wr_val  = apply_wstrb(wr_info[31:0], S_AXI_WDATA, S_AXI_WSTRB);
  end

  // AXI handshakes and register writes; accept_q marks the handshake cycle.
  always_comb begin
    cont_d    = cont_q;
    go_d      = 1'b0;
    clkdiv_d  = clkdiv_q;
    chen_d    = chen_q;
    ch_d      = ch_q;
    accept_d  = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !accept_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    arready_d = S_AXI_ARVALID && !rvalid_q && !arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (accept_q) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_info[32] ? RESP_OKAY : RESP_SLVERR;
      if (wr_word == REG_CTRL / 4) begin
        cont_d = wr_val[0];
        go_d   = wr_val[1];
      end else if (wr_word == REG_CLKDIV / 4) begin
        clkdiv_d = wr_val[15:0];
      end else if (wr_word == REG_CHEN / 4) begin
        chen_d = wr_val[N_CHANNELS-1:0];
      end else begin
        for (int i = 0; i < N_CHANNELS; i++) begin
          if (wr_word == REG_CH_BASE / 4 + i) ch_d[i] = wr_val[DATA_WIDTH-1:0];
        end
      end
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
    if (arready_q && S_AXI_ARVALID) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_info[31:0];
      rresp_d  = rd_info[32] ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_comb begin
    chen_ext = '0;
    chen_ext[N_CHANNELS-1:0] = chen_q;
    ch_sel = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (idx_q == IDX_W'(i)) ch_sel = ch_q[i];
    end
    frame_word = {idx_q[CH_BITS-1:0], ch_sel, ^{idx_q[CH_BITS-1:0], ch_sel}};
  end

  // Scan engine
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    framecnt_d = framecnt_q;
    sh_start   = 1'b0;
    sh_frame   = 1'b0;
    case (state_q)
      IDLE: if (go_q || cont_q) begin
        state_d = SEEK;
        idx_d   = '0;
      end
      SEEK: begin
        if (idx_q >= IDX_W'(N_CHANNELS)) state_d = DONE;
        else if (chen_ext[idx_q])         state_d = LOAD;
        else                              idx_d   = idx_q + 1'b1;
      end
      LOAD: begin
        sh_start = 1'b1;
        sh_frame = 1'b1;
        state_d  = SHIFT;
      end
      SHIFT: if (sh_done) begin
        sh_start = 1'b1;
        state_d  = GAP;
      end
      GAP: if (sh_done) begin
        framecnt_d = framecnt_q + 16'd1;
        idx_d      = idx_q + 1'b1;
        state_d    = SEEK;
      end
      DONE: begin
        idx_d   = '0;
        state_d = cont_q ? SEEK : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cont_q     <= 1'b0;
      go_q       <= 1'b0;
      clkdiv_q   <= 16'(DIV_RESET);
      chen_q     <= '1;
      for (int i = 0; i < N_CHANNELS; i++) ch_q[i] <= '0;
      framecnt_q <= '0;
      accept_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      state_q    <= IDLE;
      idx_q      <= '0;
    end else begin
      cont_q     <= cont_d;
      go_q       <= go_d;
      clkdiv_q   <= clkdiv_d;
      chen_q     <= chen_d;
      ch_q       <= ch_d;
      framecnt_q <= framecnt_d;
      accept_q   <= accept_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
    end
  end

  assign S_AXI_AWREADY = accept_q;
  assign S_AXI_WREADY  = accept_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign SCAN_DONE     = (state_q == DONE);

  sensor_serializer_mc_shifter #(.FRAME_LEN(FRAME_LEN)) u_shifter (
    .clk        (ACLK),
    .rst        (ARESET),
    .start_i    (sh_start),
    .frame_i    (sh_frame),
    .data_i     (frame_word),
    .clkdiv_i   (clkdiv_q),
    .ser_clk_o  (SER_CLK),
    .ser_data_o (SER_DATA),
    .ser_frame_o(SER_FRAME),
    .done_o     (sh_done)
  );

endmodule

// File: tb/tb_sensor_serializer_mc.sv
// Scoreboard bench: stimulus pushes expected frames, a monitor decodes the
// serial line and compares against them.
module tb_sensor_serializer_mc;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [7:0]  AWADDR = '0, ARADDR = '0;
  logic        AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  logic        SER_CLK, SER_DATA, SER_FRAME, SCAN_DONE;

  always #5 ACLK = ~ACLK;

  sensor_serializer_mc dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .SER_CLK(SER_CLK), .SER_DATA(SER_DATA), .SER_FRAME(SER_FRAME), .SCAN_DONE(SCAN_DONE)
  );

  typedef struct {
    int          ch;
    logic [15:0] val;
    int          div;
  } exp_t;

  exp_t        expq[$];
  int          tests = 0, fails = 0, sd_cnt = 0;
  logic [15:0] m_ch [8];
  logic [7:0]  m_chen;
  int          m_div;
  logic [15:0] m_fc;

  function automatic void chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void timeout(string name);
    tests++;
    fails++;
    $display("FAIL timeout_%s: got no event, expected one within bound", name);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_ch[i] = '0;
    m_chen = 8'hFF;
    m_div  = 4;
    m_fc   = '0;
  endfunction

  // One scan sends every enabled channel in ascending order.
  function automatic void push_scan();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      if (m_chen[i]) begin
        e.ch = i; e.val = m_ch[i]; e.div = m_div;
        expq.push_back(e);
        m_fc = m_fc + 16'd1;
      end
    end
  endfunction

  always @(negedge ACLK) if (!ARESET && SCAN_DONE) sd_cnt <= sd_cnt + 1;

  // Frame monitor: bits are taken on each SER_CLK rising edge.
  initial begin : monitor
    logic        prev_clk, prev_frm;
    logic [63:0] word;
    int          nb, len, par;
    longint      exp_w;
    exp_t        e;
    prev_clk = 0; prev_frm = 0; word = 0; nb = 0; len = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        prev_clk = 0; prev_frm = 0; word = 0; nb = 0; len = 0;
      end else begin
        if (SER_FRAME) begin
          len++;
          if (SER_CLK && !prev_clk) begin
            word = {word[62:0], SER_DATA};
            nb++;
          end
        end
        if (prev_frm && !SER_FRAME) begin
          if (expq.size() == 0) begin
            chk("frame_unexpected", word, 0);
          end else begin
            e     = expq.pop_front();
            par   = $countones({e.ch[4:0], e.val}) % 2;
            exp_w = (longint'(e.ch) << 17) + (longint'(e.val) << 1) + par;
            chk("frame_bits", word, exp_w);
            chk("frame_bitcount", nb, 22);
            chk("frame_len_cycles", len, 22 * 2 * (e.div + 1));
          end
          word = 0; nb = 0; len = 0;
        end
        prev_clk = SER_CLK;
        prev_frm = SER_FRAME;
      end
    end
  end

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int n;
    @(posedge ACLK); #1;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1; BREADY = 1;
    n = 0;
    while (!AWREADY && n < 100) begin @(posedge ACLK); #1; n++; end
    if (!AWREADY) timeout("awready");
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0;
    n = 0;
    while (!BVALID && n < 100) begin @(posedge ACLK); #1; n++; end
    if (!BVALID) timeout("bvalid");
    resp = BRESP;
    @(posedge ACLK); #1;
    BREADY = 0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(posedge ACLK); #1;
    ARADDR = a; ARVALID = 1; RREADY = 1;
    n = 0;
    while (!ARREADY && n < 100) begin @(posedge ACLK); #1; n++; end
    if (!ARREADY) timeout("arready");
    @(posedge ACLK); #1;
    ARVALID = 0;
    n = 0;
    while (!RVALID && n < 100) begin @(posedge ACLK); #1; n++; end
    if (!RVALID) timeout("rvalid");
    d = RDATA; resp = RRESP;
    @(posedge ACLK); #1;
    RREADY = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [1:0] r;
    axi_write(a, d, 4'hF, r);
    chk("bresp_okay", r, 2'b00);
  endtask

  task automatic rd_chk(string name, input logic [7:0] a, input longint exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    chk(name, d, exp);
    chk("rresp_okay", r, 2'b00);
  endtask

  task automatic wait_frame_high();
    int n = 0;
    while (!SER_FRAME && n < 3000) begin @(negedge ACLK); n++; end
    if (!SER_FRAME) timeout("ser_frame");
  endtask

  task automatic wait_sd(input int target);
    int n = 0;
    while (sd_cnt < target && n < 8000) begin @(negedge ACLK); n++; end
    if (sd_cnt < target) timeout("scan_done");
  endtask

  task automatic check_status(string name);
    @(posedge ACLK); #1;
    rd_chk(name, 8'h04, longint'(m_fc) << 8);
  endtask

  initial begin : stim
    logic [31:0] d;
    logic [1:0]  r;
    int          sd0;

    model_reset();
    #1;
    chk("reset_outputs", {AWREADY, WREADY, BVALID, ARREADY, RVALID, BRESP, RRESP, RDATA,
                          SER_CLK, SER_DATA, SER_FRAME, SCAN_DONE}, 0);
    repeat (3) @(posedge ACLK);
    #1 ARESET = 0;

    rd_chk("rst_ctrl", 8'h00, 0);
    rd_chk("rst_status", 8'h04, 0);
    rd_chk("rst_clkdiv", 8'h08, 4);
    rd_chk("rst_chen", 8'h0C, 8'hFF);
    rd_chk("rst_ch0", 8'h10, 0);

    for (int i = 0; i < 8; i++) begin
      m_ch[i] = 16'h1234 + 16'(i);
      wr(8'h10 + 8'(4 * i), 32'h1234 + 32'(i));
    end
    m_chen = 8'hA5;
    wr(8'h0C, 32'h0000_00A5);
    for (int i = 0; i < 8; i++) rd_chk("ch_readback", 8'h10 + 8'(4 * i), m_ch[i]);
    rd_chk("chen_readback", 8'h0C, 8'hA5);

    axi_write(8'h14, 32'hFFFF_FF77, 4'b0001, r);
    chk("bresp_strb", r, 2'b00);
    m_ch[1] = {m_ch[1][15:8], 8'h77};
    rd_chk("ch1_wstrb", 8'h14, m_ch[1]);

    axi_write(8'h80, 32'hDEAD_BEEF, 4'hF, r);
    chk("bresp_unmapped", r, 2'b10);
    axi_read(8'h80, d, r);
    chk("rdata_unmapped", d, 0);
    chk("rresp_unmapped", r, 2'b10);
    wr(8'h04, 32'hFFFF_FFFF);
    rd_chk("status_ro", 8'h04, 0);
    rd_chk("ch3_intact", 8'h1C, m_ch[3]);

    // One-shot frame, with a channel rewrite while it is on the wire.
    m_chen = 8'h04; m_ch[2] = 16'hBEEF; m_div = 0;
    wr(8'h0C, 32'h04); wr(8'h18, 32'hBEEF); wr(8'h08, 32'h0);
    push_scan();
    sd0 = sd_cnt;
    wr(8'h00, 32'h2);
    wait_frame_high();
    wr(8'h18, 32'h0);
    m_ch[2] = 16'h0000;
    wait_sd(sd0 + 1);
    repeat (50) @(negedge ACLK);
    chk("oneshot_scan_done_count", sd_cnt - sd0, 1);
    chk("oneshot_queue_drained", expq.size(), 0);
    check_status("status_after_oneshot");

    push_scan();
    sd0 = sd_cnt;
    wr(8'h00, 32'h2);
    wait_sd(sd0 + 1);
    repeat (10) @(negedge ACLK);
    chk("snapshot_queue_drained", expq.size(), 0);
    check_status("status_after_snapshot");

    // Continuous scan: CONT cleared during the first frame of the third scan.
    m_chen = 8'h81; m_div = 1;
    m_ch[0] = 16'($urandom); m_ch[7] = 16'($urandom);
    wr(8'h0C, 32'h81); wr(8'h08, 32'h1);
    wr(8'h10, 32'(m_ch[0])); wr(8'h2C, 32'(m_ch[7]));
    push_scan(); push_scan(); push_scan();
    sd0 = sd_cnt;
    wr(8'h00, 32'h1);
    wait_sd(sd0 + 2);
    wait_frame_high();
    wr(8'h00, 32'h0);
    wait_sd(sd0 + 3);
    repeat (400) @(negedge ACLK);
    chk("cont_scan_done_count", sd_cnt - sd0, 3);
    chk("cont_queue_drained", expq.size(), 0);
    check_status("status_after_cont");

    // Randomized one-shot scans; the first has every channel disabled.
    for (int it = 0; it < 4; it++) begin
      m_chen = (it == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      m_div  = $urandom_range(0, 2);
      wr(8'h0C, 32'(m_chen));
      wr(8'h08, 32'(m_div));
      for (int i = 0; i < 8; i++) begin
        m_ch[i] = 16'($urandom);
        wr(8'h10 + 8'(4 * i), {16'($urandom), m_ch[i]});
      end
      push_scan();
      sd0 = sd_cnt;
      wr(8'h00, 32'h2);
      wait_sd(sd0 + 1);
      repeat (10) @(negedge ACLK);
      chk("rand_queue_drained", expq.size(), 0);
      check_status("status_after_rand");
    end

    // Reset in the middle of a frame.
    wr(8'h0C, 32'h04); wr(8'h08, 32'h3); wr(8'h18, 32'h5A5A);
    wr(8'h00, 32'h2);
    wait_frame_high();
    repeat (5) @(negedge ACLK);
    @(posedge ACLK); #2;
    chk("frame_before_reset", SER_FRAME, 1);
    ARESET = 1;
    #1;
    chk("async_reset_serial", {SER_FRAME, SER_CLK, SER_DATA}, 0);
    repeat (3) @(posedge ACLK);
    #1 ARESET = 0;
    model_reset();
    rd_chk("rst2_ctrl", 8'h00, 0);
    rd_chk("rst2_status", 8'h04, 0);
    rd_chk("rst2_clkdiv", 8'h08, 4);
    rd_chk("rst2_chen", 8'h0C, 8'hFF);
    rd_chk("rst2_ch2", 8'h18, 0);
    repeat (20) @(negedge ACLK);
    chk("final_queue_empty", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
